// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: WIDTH x WIDTH unsigned multiplier sequencer. It shares one external
// combinational 2x2 core and visits every 2-bit digit pair of the operands, one pair
// per cycle, accumulating the shifted partial products.
// The optional macro MULT_EARLY_ZERO_EN skips the RUN phase when either operand is zero.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           core_a,
    output logic [1:0]           core_b,
    input  logic [3:0]           core_result
);

    localparam int unsigned N     = WIDTH / 2;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SH_W  = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [ACC_W-1:0]   acc_q;
    logic [IDX_W-1:0]   i_q;
    logic [IDX_W-1:0]   j_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [1:0]         core_a_q;
    logic [1:0]         core_b_q;

    logic [IDX_W-1:0]   i_d;
    logic [IDX_W-1:0]   j_d;
    logic [ACC_W-1:0]   acc_d;
    logic [SH_W-1:0]    shamt_c;
    logic               last_c;
    logic               early_zero_c;

    // Select 2-bit digit idx of an operand.
    function automatic logic [1:0] digit(input logic [WIDTH-1:0] op,
                                         input logic [IDX_W-1:0] idx);
        return 2'(op >> {idx, 1'b0});
    endfunction

`ifdef MULT_EARLY_ZERO_EN
    assign early_zero_c = (a == '0) || (b == '0);
`else
    assign early_zero_c = 1'b0;
`endif

    // Digit-pair walk and accumulation of the current shifted partial product.
    always_comb begin
        last_c  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
        i_d     = i_q;
        j_d     = j_q + IDX_W'(1);
        if (j_q == LAST_IDX) begin
            j_d = '0;
            i_d = i_q + IDX_W'(1);
        end
        shamt_c = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
        acc_d   = acc_q + (ACC_W'(core_result) << shamt_c);
    end

    // Control FSM with registered handshake and core-operand outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            core_a_q    <= '0;
            core_b_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a_q     <= a;
                        op_b_q     <= b;
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        if (early_zero_c) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q  <= ST_RUN;
                            core_a_q <= a[1:0];
                            core_b_q <= b[1:0];
                        end
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    if (last_c) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        i_q         <= '0;
                        j_q         <= '0;
                        core_a_q    <= '0;
                        core_b_q    <= '0;
                    end else begin
                        i_q      <= i_d;
                        j_q      <= j_d;
                        core_a_q <= digit(op_a_q, i_d);
                        core_b_q <= digit(op_b_q, j_d);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    core_a_q    <= '0;
                    core_b_q    <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = acc_q;
    assign core_a    = core_a_q;
    assign core_b    = core_b_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl (WIDTH=8) with a behavioural 2x2 core and a
// result scoreboard.
module tb_mult_seq_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = WIDTH / 2;
    localparam int unsigned LAT   = N * N;
`ifdef MULT_EARLY_ZERO_EN
    localparam bit EARLY_ZERO = 1'b1;
`else
    localparam bit EARLY_ZERO = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic [1:0]         core_a;
    logic [1:0]         core_b;
    logic [3:0]         core_result;

    int                 cyc = 0;
    int                 acc_cyc = 0;
    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [15:0]        exp_q[$];
    logic [15:0]        mon_exp;

    assign core_result = 4'(core_a) * 4'(core_b);

    mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_result (core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] tdig(input logic [7:0] v, input int idx);
        logic [7:0] t;
        t = v >> (2 * idx);
        return t[1:0];
    endfunction

    // Scoreboard pop on every result handoff.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 64'(result), 64'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 200; k++) begin
            if (in_ready === 1'b1) break;
            step();
        end
        if (in_ready !== 1'b1) check("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input bit keep);
        wait_ready();
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        step();
        acc_cyc = cyc;
        exp_q.push_back(16'(ta) * 16'(tb_));
        if (!keep) in_valid = 1'b0;
    endtask

    // Wait for out_valid, checking core operands each RUN cycle and the latency.
    task automatic wait_valid(input logic [7:0] ta, input logic [7:0] tb_, input string tag);
        bit seen;
        bit zskip;
        int s;
        int exp_lat;
        seen    = 1'b0;
        zskip   = EARLY_ZERO && (ta == 8'd0 || tb_ == 8'd0);
        exp_lat = zskip ? 1 : int'(LAT);
        for (int k = 0; k < 100; k++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            s = cyc - acc_cyc;
            check({tag, "_core_a"}, 64'(core_a), zskip ? 64'd0 : 64'(tdig(ta, s / int'(N))));
            check({tag, "_core_b"}, 64'(core_b), zskip ? 64'd0 : 64'(tdig(tb_, s % int'(N))));
            step();
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(exp_lat));
            check({tag, "_core_idle"}, 64'({core_a, core_b}), 64'd0);
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input string tag);
        send(ta, tb_, 1'b0);
        wait_valid(ta, tb_, tag);
        step();
        check({tag, "_ov_fall"}, 64'(out_valid), 64'd0);
        check({tag, "_ir_rise"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int prev;
        logic [7:0] ra;
        logic [7:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_core", 64'({core_a, core_b}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_op(8'd13, 8'd11, "op13x11");
        run_op(8'd255, 8'd255, "op255x255");
        run_op(8'd128, 8'd2, "op128x2");

        // Backpressure with in_valid held high.
        out_ready = 1'b0;
        send(8'd200, 8'd3, 1'b1);
        wait_valid(8'd200, 8'd3, "bp");
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_result", 64'(result), 64'd600);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_ov_fall", 64'(out_valid), 64'd0);
        check("bp_ir_rise", 64'(in_ready), 64'd1);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        run_op(8'd0, 8'd200, "zero");

        // Asynchronous reset mid-RUN.
        send(8'd50, 8'd60, 1'b0);
        repeat (7) step();
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_result", 64'(result), 64'd0);
        check("arst_core", 64'({core_a, core_b}), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        run_op(8'd7, 8'd9, "op7x9");

        // Back-to-back random traffic.
        out_ready = 1'b1;
        prev = 0;
        for (int k = 0; k < 20; k++) begin
            wait_ready();
            ra = 8'($urandom_range(1, 255));
            rb = 8'($urandom_range(1, 255));
            a = ra;
            b = rb;
            in_valid = 1'b1;
            step();
            exp_q.push_back(16'(ra) * 16'(rb));
            if (k > 0) check("b2b_spacing", 64'(cyc - prev), 64'(LAT + 2));
            prev = cyc;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        step();
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing controller that performs a WIDTH x WIDTH unsigned multiply by time-sharing one external combinational 2-bit x 2-bit multiplier core. The 2x2 core is the mult9-style block. The controller walks all 2-bit digit pairs of the two operands, one pair per cycle, and accumulates the shifted 4-bit partial products. It sits between a valid/ready request source and a valid/ready result sink, and owns the core's inputs.

## Interface
- WIDTH, 8, operand width in bits; must be even and >= 2; N = WIDTH/2 digits per operand
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  controller can accept a request; high only in IDLE
- a  input  WIDTH  multiplicand, sampled on the accept edge
- b  input  WIDTH  multiplier, sampled on the accept edge
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  sink accepts the result
- result  output  2*WIDTH  product a*b
- core_a  output  2  digit of a driven to the 2x2 core
- core_b  output  2  digit of b driven to the 2x2 core
- core_result  input  4  combinational product core_a*core_b returned by the core

## Operation
- States: IDLE, RUN, DONE. Registers: op_a, op_b, acc[2*WIDTH-1:0], digit indices i, j (each 0..N-1).
- IDLE: in_ready=1. On in_valid, latch a/b into op_a/op_b, clear acc, set i=j=0, go to RUN.
- RUN:
  - core_a = op_a[2i+1:2i], core_b = op_b[2j+1:2j].
  - Each cycle: acc <= acc + (core_result << 2*(i+j)).
  - j increments; on j wrap (N-1 -> 0), i increments.
  - On the step with i=j=N-1, go to DONE.
- DONE: out_valid=1, result=acc. On out_ready, go to IDLE.
- While out_ready is low, result is held stable and in_valid is ignored.
- core_a and core_b are 0 outside RUN. result is driven from acc and is also visible outside DONE; it is meaningful only while out_valid=1.
- Arithmetic: unsigned. acc is 2*WIDTH bits and cannot overflow, since the maximum product is (2^WIDTH-1)^2.
- Reset, at any time including mid-RUN or mid-DONE:
  - state=IDLE, acc=0, i=j=0, op_a=op_b=0.
  - Outputs: in_ready=1, out_valid=0, result=0, core_a=core_b=0.
  - An in-flight operation is discarded; no partial result is ever presented.

## Timing
- Accept edge: the rising edge with state=IDLE and in_valid=1.
- out_valid rises exactly N*N cycles after the accept edge. For WIDTH=8 that is 16 cycles; for WIDTH=2 it is 1 cycle.
- out_valid falls on the first edge at which out_ready=1. in_ready rises on that same edge.
- A new request is accepted no earlier than 1 cycle after result handoff. Minimum request-to-request spacing is N*N+2 cycles.
- in_ready is a function of state only. It has no combinational path from in_valid or out_ready.
- core_result is consumed in the same cycle core_a/core_b are driven; the core is combinational.

## Configuration
- MULT_EARLY_ZERO_EN defined:
  - At the accept edge, if a==0 or b==0, go directly IDLE -> DONE with acc=0. RUN is skipped.
  - out_valid rises 1 cycle after the accept edge.
  - core_a and core_b stay 0 for the whole operation.
- MULT_EARLY_ZERO_EN undefined: zero operands take the full N*N-cycle RUN sequence and produce result=0.
- Nonzero operands behave identically either way.

## Test plan
- WIDTH=8, a=13, b=11, out_ready=1 -> result=143 (16'h008F); out_valid high exactly 16 cycles after the accept edge, for 1 cycle.
- a=255, b=255 -> result=65025 (16'hFE01); a=128, b=2 -> result=256.
- Backpressure: a=200, b=3, out_ready held 0 for 5 cycles after out_valid rises, in_valid held 1 throughout -> result=600 stable, in_ready=0, no new accept until the handoff edge.
- Zero operand: a=0, b=200 -> result=0. out_valid is 1 cycle after accept with MULT_EARLY_ZERO_EN, 16 cycles without; core_a=core_b=0 throughout with the macro.
- Reset asserted asynchronously 7 cycles into RUN -> immediately out_valid=0, in_ready=1, result=0, core_a=core_b=0. Following request a=7, b=9 returns 63 with normal latency.
- Back-to-back: 20 random operand pairs, in_valid and out_ready held 1 -> every result matches a*b; accept edges spaced exactly 18 cycles apart.
